// File: rtl/fetch_unit_if.sv
// Controller command bus and program-load port of fetch_unit.
// The master side is the controller or test harness; the slave side is the fetch unit.
interface fetch_unit_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
);
    logic               PC_clr;
    logic [PC_W-1:0]    PC_up;
    logic               IR_ld;
    logic [INSTR_W-1:0] IR;
    logic [PC_W-1:0]    PC;

    logic               prog_en;
    logic               prog_valid;
    logic               prog_ready;
    logic [PC_W-1:0]    prog_addr;
    logic [INSTR_W-1:0] prog_data;

    logic               run_rdy;
    logic               fetch_err;
    logic [15:0]        fetch_count;

    modport master (
        output PC_clr, PC_up, IR_ld,
        output prog_en, prog_valid, prog_addr, prog_data,
        input  IR, PC, prog_ready, run_rdy, fetch_err, fetch_count
    );

    modport slave (
        input  PC_clr, PC_up, IR_ld,
        input  prog_en, prog_valid, prog_addr, prog_data,
        output IR, PC, prog_ready, run_rdy, fetch_err, fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch responder: owns PC, synchronous instruction memory and IR.
// Optional FETCH_TRACE_EN macro enables the saturating fetch_count counter.
module fetch_unit #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        LOAD,
        PRIME,
        RUN
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_next;
    logic [INSTR_W-1:0] ir;
    logic [INSTR_W-1:0] rdata;
    logic [INSTR_W-1:0] mem [0:(1<<PC_W)-1];
    logic               pc_moved;
    logic               err;
    logic               cmd_en;
    logic               prog_ready;
    logic               run_rdy;
    logic               mem_we;
    logic               ir_ld_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PRIME;
        end else begin
            state <= state_next;
        end
    end

    // Commands are honoured only in RUN when no load request is pending.
    always_comb begin
        state_next = state;
        prog_ready = 1'b0;
        run_rdy    = 1'b0;
        cmd_en     = 1'b0;
        case (state)
            PRIME: begin
                state_next = bus.prog_en ? LOAD : RUN;
            end
            LOAD: begin
                prog_ready = 1'b1;
                if (!bus.prog_en) begin
                    state_next = PRIME;
                end
            end
            RUN: begin
                run_rdy = 1'b1;
                if (bus.prog_en) begin
                    state_next = LOAD;
                end else begin
                    cmd_en = 1'b1;
                end
            end
            default: begin
                state_next = PRIME;
            end
        endcase
    end

    always_comb begin
        pc_next = '0;
        if (cmd_en) begin
            pc_next = bus.PC_clr ? '0 : pc + bus.PC_up;
        end
    end

    assign mem_we   = prog_ready && bus.prog_valid && !rst;
    assign ir_ld_en = cmd_en && bus.IR_ld;

    // Read port uses the current PC, so rdata trails any PC change by one cycle.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[bus.prog_addr] <= bus.prog_data;
        end
        rdata <= mem[pc];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= '0;
            ir       <= '0;
            err      <= 1'b0;
            pc_moved <= 1'b0;
        end else begin
            pc       <= pc_next;
            pc_moved <= (pc_next != pc);
            if (ir_ld_en) begin
                ir <= rdata;
                if (pc_moved) begin
                    err <= 1'b1;
                end
            end
        end
    end

`ifdef FETCH_TRACE_EN
    logic [15:0] fetch_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
        end else if (ir_ld_en && (fetch_cnt != 16'hFFFF)) begin
            fetch_cnt <= fetch_cnt + 16'd1;
        end
    end

    assign bus.fetch_count = fetch_cnt;
`else
    assign bus.fetch_count = '0;
`endif

    assign bus.IR         = ir;
    assign bus.PC         = pc;
    assign bus.prog_ready = prog_ready;
    assign bus.run_rdy    = run_rdy;
    assign bus.fetch_err  = err;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed test-plan steps plus random commands,
// checked against a behavioural model of the memory, PC and IR rules.
module tb_fetch_unit;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;

    typedef struct {
        bit [7:0]  pc;
        bit [15:0] ir;
        bit        err;
        bit [15:0] cnt;
        bit        pready;
        bit        rrdy;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks = 0;
    int   passes = 0;
    exp_t exp_q[$];

    // Reference model: mode name, memory image, PC, IR and the address rdata reflects.
    string     m_mode = "PRIME";
    bit [15:0] m_mem [256];
    bit [7:0]  m_pc = 0;
    bit [15:0] m_ir = 0;
    bit [15:0] m_rd = 0;
    bit [7:0]  m_rd_addr = 0;
    bit        m_err = 0;
    bit [15:0] m_cnt = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit pe, input bit pv, input bit [7:0] pa,
                                 input bit [15:0] pd, input bit clr, input bit [7:0] up, input bit ild);
        exp_t      e;
        bit [15:0] rd_new;
        bit [7:0]  rd_addr_new;
        rst            = r;
        bus.prog_en    = pe;
        bus.prog_valid = pv;
        bus.prog_addr  = pa;
        bus.prog_data  = pd;
        bus.PC_clr     = clr;
        bus.PC_up      = up;
        bus.IR_ld      = ild;

        rd_new      = m_mem[m_pc];
        rd_addr_new = m_pc;
        if (r) begin
            m_mode = "PRIME";
            m_pc   = 0;
            m_ir   = 0;
            m_err  = 0;
            m_cnt  = 0;
        end else if (m_mode == "PRIME") begin
            m_mode = pe ? "LOAD" : "RUN";
            m_pc   = 0;
        end else if (m_mode == "LOAD") begin
            if (pv) m_mem[pa] = pd;
            m_mode = pe ? "LOAD" : "PRIME";
            m_pc   = 0;
        end else if (pe) begin
            m_mode = "LOAD";
            m_pc   = 0;
        end else begin
            if (ild) begin
                m_ir = m_rd;
                if (m_rd_addr != m_pc) m_err = 1;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
            end
            m_pc = clr ? 8'd0 : m_pc + up;
        end
        m_rd      = rd_new;
        m_rd_addr = rd_addr_new;

        e.pc     = m_pc;
        e.ir     = m_ir;
        e.err    = m_err;
`ifdef FETCH_TRACE_EN
        e.cnt    = m_cnt;
`else
        e.cnt    = 16'd0;
`endif
        e.pready = (m_mode == "LOAD");
        e.rrdy   = (m_mode == "RUN");
        exp_q.push_back(e);

        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 8'd0, 16'd0, 0, 8'd0, 0);
    endtask

    task automatic cmd(input bit clr, input bit [7:0] up, input bit ild);
        applyStimulus(0, 0, 0, 8'd0, 16'd0, clr, up, ild);
    endtask

    // Monitor: every cycle with an outstanding expectation is compared after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("PC", 32'(bus.PC), 32'(e.pc));
                checkOutput("IR", 32'(bus.IR), 32'(e.ir));
                checkOutput("fetch_err", 32'(bus.fetch_err), 32'(e.err));
                checkOutput("fetch_count", 32'(bus.fetch_count), 32'(e.cnt));
                checkOutput("prog_ready", 32'(bus.prog_ready), 32'(e.pready));
                checkOutput("run_rdy", 32'(bus.run_rdy), 32'(e.rrdy));
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int load_left;
        bit r, pe;

        applyStimulus(1, 0, 0, 8'd0, 16'd0, 0, 8'd0, 0);
        applyStimulus(1, 0, 0, 8'd0, 16'd0, 0, 8'd0, 0);
        checkOutput("reset_PC", 32'(bus.PC), 32'd0);
        checkOutput("reset_IR", 32'(bus.IR), 32'd0);

        // Commands in LOAD must be ignored.
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 8'd0, 16'd0, 0, 8'd1, 1);
        checkOutput("gate_PC", 32'(bus.PC), 32'd0);
        checkOutput("gate_IR", 32'(bus.IR), 32'd0);
        checkOutput("gate_prog_ready", 32'(bus.prog_ready), 32'd1);

        for (int i = 2; i < 256; i++) applyStimulus(0, 1, 1, 8'(i), 16'($urandom), 0, 8'd0, 0);
        applyStimulus(0, 1, 1, 8'd0, 16'h2123, 0, 8'd0, 0);
        applyStimulus(0, 1, 1, 8'd1, 16'h3456, 0, 8'd0, 0);

        applyStimulus(0, 0, 0, 8'd0, 16'd0, 0, 8'd0, 0);
        idle();
        checkOutput("run_rdy_up", 32'(bus.run_rdy), 32'd1);
        idle();
        cmd(0, 8'd1, 1);
        checkOutput("fetch0_IR", 32'(bus.IR), 32'h2123);
        checkOutput("fetch0_PC", 32'(bus.PC), 32'd1);
        idle();
        cmd(0, 8'd1, 1);
        checkOutput("fetch1_IR", 32'(bus.IR), 32'h3456);
        checkOutput("fetch1_PC", 32'(bus.PC), 32'd2);

        cmd(0, 8'hFC, 0);
        cmd(0, 8'h05, 0);
        checkOutput("wrap_fwd_PC", 32'(bus.PC), 32'h03);
        cmd(0, 8'hFD, 0);
        checkOutput("wrap_back_PC", 32'(bus.PC), 32'h00);

        cmd(0, 8'h40, 0);
        cmd(1, 8'h07, 0);
        checkOutput("clr_prio_PC", 32'(bus.PC), 32'd0);

        // Writes while in RUN must not reach memory.
        applyStimulus(0, 0, 1, 8'd5, 16'hBEEF, 0, 8'd0, 0);
        cmd(0, 8'd5, 0);
        idle();
        cmd(0, 8'd1, 1);

        idle();
        cmd(0, 8'd1, 0);
        cmd(0, 8'd0, 1);
        checkOutput("hazard_err", 32'(bus.fetch_err), 32'd1);
        idle();
        cmd(0, 8'd1, 1);
        checkOutput("hazard_sticky", 32'(bus.fetch_err), 32'd1);

        load_left = 0;
        for (int i = 0; i < 600; i++) begin
            if (load_left > 0) begin
                pe = 1;
                load_left--;
            end else begin
                pe = 0;
                if ($urandom_range(0, 39) == 0) load_left = int'($urandom_range(1, 6));
            end
            r = ($urandom_range(0, 99) == 0);
            applyStimulus(r, pe, 1'($urandom), 8'($urandom), 16'($urandom),
                          ($urandom_range(0, 9) == 0), 8'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 1)),
                          1'($urandom));
        end

        applyStimulus(1, 0, 0, 8'd0, 16'd0, 0, 8'd0, 0);
        checkOutput("final_reset_err", 32'(bus.fetch_err), 32'd0);
        idle();
        idle();

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
